// File: rtl/mdu.sv
//------------------------------------------------------------------------------
// Module   : mdu
// Purpose  : Iterative multiply/divide unit for the EX stage. Executes
//            MULT/MULTU/DIV/DIVU in W+1 cycles (W iterations plus one
//            sign fix-up/commit cycle) and owns the architectural HI/LO
//            registers. MTHI/MTLO complete in a single cycle.
// Ports    : clk     - clock, all state changes on the rising edge
//            rst_n   - synchronous reset, active low
//            start   - request, sampled only while busy=0
//            mdu_op  - 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//            op1     - rs value (multiplicand / dividend / MTHI-MTLO source)
//            op2     - rt value (multiplier / divisor)
//            cancel  - exception flush, aborts the in-flight operation
//            busy    - operation in progress
//            done    - one-cycle pulse after HI/LO commit by MULT*/DIV*
//            hi, lo  - architectural HI and LO registers
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mdu #(
  parameter int W   = 32,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] mdu_op,
  input  logic [W-1:0]   op1,
  input  logic [W-1:0]   op2,
  input  logic           cancel,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);

  localparam int CNTW = $clog2(W);

  localparam logic [OPW-1:0] OP_MULT  = OPW'(1);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(2);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(4);
  localparam logic [OPW-1:0] OP_MTHI  = OPW'(5);
  localparam logic [OPW-1:0] OP_MTLO  = OPW'(6);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            is_div;
  logic            neg_q;      // negate product / quotient in FIX
  logic            neg_r;      // negate remainder in FIX
  logic            div_zero;
  logic [W-1:0]    op1_orig;   // unmodified dividend for divide-by-zero HI
  logic [W-1:0]    opb;        // multiplicand or divisor magnitude
  logic [W-1:0]    acc_hi;     // product upper half / partial remainder
  logic [W-1:0]    acc_lo;     // multiplier bits / dividend bits -> quotient

  // Decode and operand magnitudes for the accepting edge.
  logic         is_muldiv;
  logic         is_divop;
  logic         signed_op;
  logic         a_neg;
  logic         b_neg;
  logic [W-1:0] mag_a;
  logic [W-1:0] mag_b;

  always_comb begin
    is_muldiv = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    is_divop  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    signed_op = (mdu_op == OP_MULT) || (mdu_op == OP_DIV);
    a_neg     = signed_op & op1[W-1];
    b_neg     = signed_op & op2[W-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(W-1).
    mag_a     = a_neg ? (~op1 + 1'b1) : op1;
    mag_b     = b_neg ? (~op2 + 1'b1) : op2;
  end

  // One iteration of shift-add multiply or restoring divide.
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W:0]   div_diff;
  logic         div_ge;

  always_comb begin
    // Multiply: add multiplicand when the current multiplier LSB is set,
    // then shift the {carry, acc_hi, acc_lo} chain right by one.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(W+1){1'b0}});
    // Divide: bring the next dividend bit into the partial remainder and
    // trial-subtract; a non-negative result means the quotient bit is 1.
    div_shift = {acc_hi, acc_lo[W-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = ~div_diff[W];
  end

  // Sign fix-up values applied at the commit edge.
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    quo_fix  = neg_q ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix  = neg_r ? (~acc_hi + 1'b1) : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      op1_orig <= '0;
      opb      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // cancel suppresses every request, including MTHI/MTLO.
          if (start && !cancel) begin
            if (is_muldiv) begin
              state    <= S_CALC;
              busy     <= 1'b1;
              cnt      <= CNTW'(W-1);
              is_div   <= is_divop;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= is_divop && (op2 == '0);
              op1_orig <= op1;
              // Multiplication is commutative, so op1 serves as the
              // multiplier for MULT* and as the dividend for DIV*.
              opb      <= mag_b;
              acc_hi   <= '0;
              acc_lo   <= mag_a;
            end else if (mdu_op == OP_MTHI) begin
              hi <= op1;
            end else if (mdu_op == OP_MTLO) begin
              lo <= op1;
            end
          end
        end

        S_CALC: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              acc_hi <= div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
              acc_lo <= {acc_lo[W-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[W:1];
              acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
            end
            if (cnt == '0) begin
              state <= S_FIX;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end

        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              hi <= op1_orig;
              lo <= {W{1'b1}};
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
//------------------------------------------------------------------------------
// Module   : tb_mdu
// Purpose  : Self-checking bench for mdu. Directed vectors with hand-computed
//            HI/LO results plus sequences for cancel, reset, ignored starts
//            and back-to-back issue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  mdu #(.W(32), .OPW(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mdu_op (mdu_op),
    .op1    (op1),
    .op2    (op2),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Counts negedges with busy=1 and watches that hi/lo hold the model values.
  task automatic wait_done(output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (hi !== m_hi || lo !== m_lo) stable = 1'b0;
      @(negedge clk);
    end
  endtask

  // Issue at the current negedge and run to the done cycle.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    bit st;
    start = 1'b1; mdu_op = v.op; op1 = v.a; op2 = v.b;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    chk({tag, "_busy_on"}, {31'b0, busy}, 32'd1);
    chk({tag, "_done_low"}, {31'b0, done}, 32'd0);
    wait_done(n, st);
    chk({tag, "_cycles"}, n, 32'd33);
    chk({tag, "_stable"}, {31'b0, st}, 32'd1);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_hi"}, hi, v.eh);
    chk({tag, "_lo"}, lo, v.el);
    m_hi = v.eh;
    m_lo = v.el;
  endtask

  initial begin
    int n;
    bit st;
    bit bad;

    vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd4, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6]  = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[9]  = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'h00000000, 32'h00000004};
    vecs[10] = '{3'd3, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[12] = '{3'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; cancel = 1'b0;
    mdu_op = 3'd0; op1 = '0; op2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(negedge clk);

    // MTHI / MTLO complete in one edge without busy.
    start = 1'b1; mdu_op = 3'd5; op1 = 32'h55;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    chk("mthi_hi", hi, 32'h55);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    chk("mthi_done", {31'b0, done}, 32'd0);
    start = 1'b1; mdu_op = 3'd6; op1 = 32'h66;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    chk("mtlo_lo", lo, 32'h66);
    chk("mtlo_hi_kept", hi, 32'h55);
    m_hi = 32'h55; m_lo = 32'h66;

    // cancel with start in IDLE: nothing executes.
    start = 1'b1; mdu_op = 3'd5; op1 = 32'hDEAD; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0; cancel = 1'b0;
    chk("cancel_idle_hi", hi, 32'h55);
    chk("cancel_idle_busy", {31'b0, busy}, 32'd0);

    // Table vectors; each one after the first is issued in the done cycle.
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start MTLO while busy is ignored.
    @(negedge clk);
    chk("post_done_low", {31'b0, done}, 32'd0);
    start = 1'b1; mdu_op = 3'd2; op1 = 32'd2; op2 = 32'd3;
    @(negedge clk);
    mdu_op = 3'd6; op1 = 32'hAA;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    wait_done(n, st);
    chk("mtlo_busy_cycles", n, 32'd32);
    chk("mtlo_busy_stable", {31'b0, st}, 32'd1);
    chk("mtlo_busy_done", {31'b0, done}, 32'd1);
    chk("mtlo_busy_hi", hi, 32'd0);
    chk("mtlo_busy_lo", lo, 32'd6);
    m_hi = 32'd0; m_lo = 32'd6;

    // cancel mid-operation: busy drops, no done, hi/lo unchanged.
    @(negedge clk);
    start = 1'b1; mdu_op = 3'd2; op1 = 32'd5; op2 = 32'd7;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    repeat (8) @(negedge clk);
    chk("cancel_pre_busy", {31'b0, busy}, 32'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {31'b0, busy}, 32'd0);
    chk("cancel_done", {31'b0, done}, 32'd0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("cancel_quiet", {31'b0, bad}, 32'd0);
    chk("cancel_hi", hi, m_hi);
    chk("cancel_lo", lo, m_lo);

    // Reset mid-operation clears everything.
    start = 1'b1; mdu_op = 3'd1; op1 = 32'hFFFFFFFE; op2 = 32'd3;
    @(negedge clk);
    start = 1'b0; mdu_op = 3'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    run_vec(vecs[6], "after_reset");

    // DIVU issued in the done cycle is accepted.
    run_vec(vecs[3], "b2b_divu");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
